// File: rtl/proc_boot_ctrl.sv
// Boot, run and dump controller for the MIPS single-cycle core.
// Loads a program into instruction memory, releases the core until it fetches
// HALT_WORD or hits MAX_CYCLES, then streams the register file out on a valid/ready port.
// Optional build macro DMEM_DUMP_EN appends a data-memory dump after the register dump.
module proc_boot_ctrl #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       PROG_DEPTH = 8,
    parameter int unsigned       LEN_W      = $clog2(PROG_DEPTH + 1),
    parameter int unsigned       REG_COUNT  = 32,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(32'hFC000000),
    parameter int unsigned       MAX_CYCLES = 1000,
    parameter int unsigned       CYC_W      = 16,
    parameter int unsigned       DMEM_WORDS = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    input  logic [LEN_W-1:0]  progLen,
    input  logic              progValid,
    input  logic [DATA_W-1:0] progData,
    output logic              progReady,
    output logic              imemWrite,
    output logic [31:0]       imemAddr,
    output logic [DATA_W-1:0] imemData,
    input  logic [DATA_W-1:0] fetchedInstr,
    output logic              coreHold,
    output logic              pcWrite,
    output logic [4:0]        regRdAddr,
    input  logic [DATA_W-1:0] regRdData,
    output logic [31:0]       dmemRdAddr,
    input  logic [DATA_W-1:0] dmemRdData,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic              dumpSel,
    output logic [31:0]       dumpAddr,
    output logic [DATA_W-1:0] dumpData,
    output logic [CYC_W-1:0]  cycleCount,
    output logic              timeout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = 5;

    typedef enum logic [2:0] {
        StIdle, StLoad, StRun, StDumpReg, StDmemReq, StDmemOut, StDone
    } state_e;

    state_e            stateQ, stateD;
    logic [LEN_W-1:0]  lenQ, lenD;
    logic [LEN_W-1:0]  loadIdxQ, loadIdxD;
    logic [CYC_W-1:0]  cycQ, cycD;
    logic              timeoutQ, timeoutD;
    logic [IDX_W-1:0]  dumpIdxQ, dumpIdxD;
    logic [LEN_W-1:0]  effLen;
    logic              haltHit;

`ifdef DMEM_DUMP_EN
    localparam int unsigned MEM_W = $clog2(DMEM_WORDS + 1);
    logic [MEM_W-1:0]  memIdxQ, memIdxD;
    logic [31:0]       memAddr;
    assign memAddr = {{(30 - MEM_W){1'b0}}, memIdxQ, 2'b00};
`else
    logic unusedDmem;
    assign unusedDmem = ^dmemRdData;
`endif

    // Requests longer than the program buffer are clipped to PROG_DEPTH words.
    assign effLen  = (progLen > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : progLen;
    assign haltHit = (fetchedInstr == HALT_WORD);

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            stateQ   <= StIdle;
            lenQ     <= '0;
            loadIdxQ <= '0;
            cycQ     <= '0;
            timeoutQ <= 1'b0;
            dumpIdxQ <= '0;
`ifdef DMEM_DUMP_EN
            memIdxQ  <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            lenQ     <= lenD;
            loadIdxQ <= loadIdxD;
            cycQ     <= cycD;
            timeoutQ <= timeoutD;
            dumpIdxQ <= dumpIdxD;
`ifdef DMEM_DUMP_EN
            memIdxQ  <= memIdxD;
`endif
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        stateD     = stateQ;
        lenD       = lenQ;
        loadIdxD   = loadIdxQ;
        cycD       = cycQ;
        timeoutD   = timeoutQ;
        dumpIdxD   = dumpIdxQ;
`ifdef DMEM_DUMP_EN
        memIdxD    = memIdxQ;
`endif
        progReady  = 1'b0;
        imemWrite  = 1'b0;
        imemAddr   = '0;
        imemData   = '0;
        coreHold   = 1'b1;
        pcWrite    = 1'b0;
        regRdAddr  = '0;
        dmemRdAddr = '0;
        dumpValid  = 1'b0;
        dumpSel    = 1'b0;
        dumpAddr   = '0;
        dumpData   = '0;

        case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    lenD     = effLen;
                    loadIdxD = '0;
                    cycD     = '0;
                    timeoutD = 1'b0;
                    dumpIdxD = '0;
`ifdef DMEM_DUMP_EN
                    memIdxD  = '0;
`endif
                    stateD   = (effLen == '0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                progReady = 1'b1;
                imemWrite = progValid;
                imemAddr  = {{(30 - LEN_W){1'b0}}, loadIdxQ, 2'b00};
                imemData  = progData;
                if (progValid) begin
                    loadIdxD = loadIdxQ + LEN_W'(1);
                    if (loadIdxQ == lenQ - LEN_W'(1)) begin
                        stateD = StRun;
                    end
                end
            end
            StRun: begin
                coreHold = 1'b0;
                // Holding the PC on the halt word keeps it from running past the program end.
                pcWrite  = ~haltHit;
                if (haltHit) begin
                    stateD   = StDumpReg;
                    timeoutD = 1'b0;
                end else if (cycQ == CYC_W'(MAX_CYCLES - 1)) begin
                    stateD   = StDumpReg;
                    timeoutD = 1'b1;
                end else begin
                    cycD = cycQ + CYC_W'(1);
                end
            end
            StDumpReg: begin
                regRdAddr = dumpIdxQ;
                dumpValid = 1'b1;
                dumpAddr  = {{(32 - IDX_W){1'b0}}, dumpIdxQ};
                dumpData  = regRdData;
                if (dumpReady) begin
                    dumpIdxD = dumpIdxQ + IDX_W'(1);
                    if (dumpIdxQ == IDX_W'(REG_COUNT - 1)) begin
`ifdef DMEM_DUMP_EN
                        stateD = StDmemReq;
`else
                        stateD = StDone;
`endif
                    end
                end
            end
`ifdef DMEM_DUMP_EN
            StDmemReq: begin
                dmemRdAddr = memAddr;
                stateD     = StDmemOut;
            end
            StDmemOut: begin
                // Address stays put so the registered read data is stable under backpressure.
                dmemRdAddr = memAddr;
                dumpValid  = 1'b1;
                dumpSel    = 1'b1;
                dumpAddr   = memAddr;
                dumpData   = dmemRdData;
                if (dumpReady) begin
                    memIdxD = memIdxQ + MEM_W'(1);
                    stateD  = (memIdxQ == MEM_W'(DMEM_WORDS - 1)) ? StDone : StDmemReq;
                end
            end
`endif
            default: stateD = StIdle;
        endcase
    end

    assign cycleCount = cycQ;
    assign timeout    = timeoutQ;
    assign done       = (stateQ == StDone);
    assign busy       = (stateQ != StIdle) && (stateQ != StDone);

endmodule

// File: tb/tb_proc_boot_ctrl.sv
// Self-checking bench for proc_boot_ctrl: a tiny core/memory environment, an ISA-level
// model that predicts writes, dump beats, cycleCount and timeout, and a per-cycle compare.
module tb_proc_boot_ctrl;

    localparam int DATA_W     = 32;
    localparam int PROG_DEPTH = 8;
    localparam int LEN_W      = 4;
    localparam int REG_COUNT  = 32;
    localparam int MAX_CYCLES = 10;
    localparam int CYC_W      = 16;
    localparam int DMEM_WORDS = 16;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  progLen = '0;
    logic              progValid = 1'b0;
    logic [31:0]       progData = '0;
    logic              progReady, imemWrite, coreHold, pcWrite;
    logic [31:0]       imemAddr, imemData, fetchedInstr;
    logic [4:0]        regRdAddr;
    logic [31:0]       regRdData, dmemRdAddr, dmemRdData;
    logic              dumpValid, dumpReady, dumpSel;
    logic [31:0]       dumpAddr, dumpData;
    logic [CYC_W-1:0]  cycleCount;
    logic              timeout, busy, done;

    proc_boot_ctrl #(
        .DATA_W(DATA_W), .PROG_DEPTH(PROG_DEPTH), .LEN_W(LEN_W), .REG_COUNT(REG_COUNT),
        .HALT_WORD(HALT), .MAX_CYCLES(MAX_CYCLES), .CYC_W(CYC_W), .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start), .progLen(progLen),
        .progValid(progValid), .progData(progData), .progReady(progReady),
        .imemWrite(imemWrite), .imemAddr(imemAddr), .imemData(imemData),
        .fetchedInstr(fetchedInstr), .coreHold(coreHold), .pcWrite(pcWrite),
        .regRdAddr(regRdAddr), .regRdData(regRdData),
        .dmemRdAddr(dmemRdAddr), .dmemRdData(dmemRdData),
        .dumpValid(dumpValid), .dumpReady(dumpReady), .dumpSel(dumpSel),
        .dumpAddr(dumpAddr), .dumpData(dumpData), .cycleCount(cycleCount),
        .timeout(timeout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dmemInit(input int i);
        return (i == 0) ? 32'h12345678 : 32'hA5000000 + 32'(i);
    endfunction

    // ---------------- environment: memories, PC and a core that only executes addi
    logic [31:0] imem [64];
    logic [31:0] rf [32];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] pc;
    logic        clearReq = 1'b0;

    assign fetchedInstr = imem[pc[7:2]];
    assign regRdData    = rf[regRdAddr];

    always @(posedge clk) begin
        if (clearReq) begin
            for (int i = 0; i < 64; i++) imem[i] <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= dmemInit(i);
        end else begin
            if (imemWrite) imem[imemAddr[7:2]] <= imemData;
            if (!coreHold && fetchedInstr[31:26] == 6'h08 && fetchedInstr[20:16] != 5'd0)
                rf[fetchedInstr[20:16]] <= rf[fetchedInstr[25:21]]
                                           + {{16{fetchedInstr[15]}}, fetchedInstr[15:0]};
        end
        pc <= coreHold ? 32'd0 : (pcWrite ? pc + 32'd4 : pc);
        dmemRdData <= dmem[dmemRdAddr[5:2]];
    end

    // ---------------- ISA-level model
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic sel; logic [31:0] addr; logic [31:0] data; } beat_t;
    wr_t         expWr[$];
    beat_t       expBeat[$];
    int          expCount;
    logic        expTo;
    logic [31:0] prog [16];

    task automatic buildModel(input int len);
        logic [31:0] mem [64];
        logic [31:0] regs [32];
        int effLen;
        logic [31:0] ins;
        effLen = (len > PROG_DEPTH) ? PROG_DEPTH : len;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < effLen; i++) begin
            mem[i] = prog[i];
            expWr.push_back('{addr: 32'(i * 4), data: prog[i]});
        end
        // Cycle k of RUN fetches word k; the halt cycle or the last allowed cycle sets the count.
        expTo = 1'b1;
        expCount = MAX_CYCLES - 1;
        for (int k = 0; k < MAX_CYCLES; k++) begin
            ins = mem[k];
            if (ins == HALT) begin
                expTo = 1'b0;
                expCount = k;
                break;
            end
            if (ins[31:26] == 6'h08 && ins[20:16] != 0)
                regs[ins[20:16]] = regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        end
        for (int r = 0; r < REG_COUNT; r++)
            expBeat.push_back('{sel: 1'b0, addr: 32'(r), data: regs[r]});
`ifdef DMEM_DUMP_EN
        for (int m = 0; m < DMEM_WORDS; m++)
            expBeat.push_back('{sel: 1'b1, addr: 32'(m * 4), data: dmemInit(m)});
`endif
    endtask

    // ---------------- sink backpressure
    logic toggleReady = 1'b0;
    initial begin
        dumpReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dumpReady = toggleReady ? ~dumpReady : 1'b1;
        end
    end

    // ---------------- per-cycle compare against the model
    logic        prevValid = 1'b0, prevReady = 1'b0, prevSel = 1'b0, prevDone = 1'b0;
    logic [31:0] prevAddr = '0, prevData = '0;
    logic [31:0] gotReg [32];
    logic [31:0] gotMem0 = '0;
    logic [31:0] lastRunPc = '0;
    logic        lastPcWrite = 1'b0;
    wr_t         w;
    beat_t       b;

    always @(negedge clk) begin
        if (resetN) begin
            if (imemWrite) begin
                if (expWr.size() == 0) begin
                    check("imem_unexpected_write", imemAddr, 32'hFFFFFFFF);
                end else begin
                    w = expWr.pop_front();
                    check("imem_addr", imemAddr, w.addr);
                    check("imem_data", imemData, w.data);
                end
            end
            if (dumpValid && prevValid && !prevReady) begin
                check("dump_hold_addr", dumpAddr, prevAddr);
                check("dump_hold_data", dumpData, prevData);
                check("dump_hold_sel", 32'(dumpSel), 32'(prevSel));
            end
            if (dumpValid && dumpReady) begin
                if (!dumpSel) gotReg[dumpAddr[4:0]] = dumpData;
                else if (dumpAddr == 0) gotMem0 = dumpData;
                if (expBeat.size() == 0) begin
                    check("dump_unexpected_beat", dumpAddr, 32'hFFFFFFFF);
                end else begin
                    b = expBeat.pop_front();
                    check("dump_sel", 32'(dumpSel), 32'(b.sel));
                    check("dump_addr", dumpAddr, b.addr);
                    check("dump_data", dumpData, b.data);
                end
            end
            if (!coreHold) begin
                lastRunPc = pc;
                lastPcWrite = pcWrite;
            end
            if (pcWrite && coreHold) check("pcwrite_while_held", 32'(pcWrite), 32'd0);
            if (done && !prevDone) begin
                check("done_cycle_count", 32'(cycleCount), 32'(expCount));
                check("done_timeout", 32'(timeout), 32'(expTo));
                check("done_beats_left", 32'(expBeat.size()), 32'd0);
                check("done_busy", 32'(busy), 32'd0);
            end
            prevValid = dumpValid;
            prevReady = dumpReady;
            prevSel   = dumpSel;
            prevAddr  = dumpAddr;
            prevData  = dumpData;
            prevDone  = done;
        end else begin
            prevValid = 1'b0;
            prevDone  = 1'b0;
        end
    end

    // ---------------- stimulus helpers
    task automatic clearEnv();
        expWr.delete();
        expBeat.delete();
        for (int i = 0; i < 32; i++) gotReg[i] = 32'hDEADBEEF;
        gotMem0 = '0;
        clearReq = 1'b1;
        @(posedge clk);
        #1;
        clearReq = 1'b0;
    endtask

    task automatic pulseStart(input int len);
        @(posedge clk);
        #1;
        start = 1'b1;
        progLen = LEN_W'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_coreHold"}, 32'(coreHold), 32'd1);
        check({tag, "_progReady"}, 32'(progReady), 32'd0);
        check({tag, "_imemWrite"}, 32'(imemWrite), 32'd0);
        check({tag, "_pcWrite"}, 32'(pcWrite), 32'd0);
        check({tag, "_dumpValid"}, 32'(dumpValid), 32'd0);
        check({tag, "_cycleCount"}, 32'(cycleCount), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Feeds nWords words (stalling before word stallAt), then waits for done.
    task automatic runTest(input string tag, input int len, input int nWords,
                           input int stallAt, input bit startInRun, output int accepted);
        bit got;
        bit finished;
        clearEnv();
        buildModel(len);
        pulseStart(len);
        accepted = 0;
        for (int i = 0; i < nWords; i++) begin
            if (i == stallAt) begin
                progValid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            progValid = 1'b1;
            progData = prog[i];
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                @(negedge clk);
                if (progReady) got = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!got) break;
            accepted++;
        end
        progValid = 1'b0;
        if (startInRun) begin
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (!coreHold) break;
            end
            @(posedge clk);
            #1;
            start = 1'b1;
            progLen = LEN_W'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        finished = 1'b0;
        for (int t = 0; t < 400 && !finished; t++) begin
            @(negedge clk);
            if (done) finished = 1'b1;
        end
        if (!finished) check({tag, "_done_wait_expired"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_writes_left"}, 32'(expWr.size()), 32'd0);
        check({tag, "_beats_left"}, 32'(expBeat.size()), 32'd0);
    endtask

    // ---------------- directed sequence
    int acc;
    initial begin
        clearEnv();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("por");
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Reset in the middle of a two-word load.
        clearEnv();
        expWr.push_back('{addr: 32'd0, data: 32'h20010001});
        pulseStart(2);
        progValid = 1'b1;
        progData = 32'h20010001;
        @(negedge clk);
        check("midload_ready", 32'(progReady), 32'd1);
        @(posedge clk);
        #1;
        progValid = 1'b0;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midload_reset");
        check("midload_writes", 32'(expWr.size()), 32'd0);

        // Halt program, with a start pulse during RUN that must be ignored.
        prog[0] = 32'h20100002;
        prog[1] = 32'h22100003;
        prog[2] = HALT;
        runTest("halt", 3, 3, 99, 1'b1, acc);
        check("halt_accepted", 32'(acc), 32'd3);
        check("halt_cycleCount", 32'(cycleCount), 32'd2);
        check("halt_timeout", 32'(timeout), 32'd0);
        check("halt_reg16", gotReg[16], 32'd5);
        check("halt_last_pc", lastRunPc, 32'd8);
        check("halt_last_pcWrite", 32'(lastPcWrite), 32'd0);
        check("halt_done", 32'(done), 32'd1);
`ifdef DMEM_DUMP_EN
        check("halt_dmem0", gotMem0, 32'h12345678);
`endif

        // Same program under alternating backpressure.
        toggleReady = 1'b1;
        runTest("bp", 3, 3, 99, 1'b0, acc);
        check("bp_reg16", gotReg[16], 32'd5);
        check("bp_reg31", gotReg[31], 32'd0);
        toggleReady = 1'b0;

        // No halt word: timeout after MAX_CYCLES RUN cycles, with a load stall.
        prog[0] = 32'h20010001;
        prog[1] = 32'h20210001;
        prog[2] = 32'h20210001;
        runTest("tmo", 3, 3, 1, 1'b0, acc);
        check("tmo_cycleCount", 32'(cycleCount), 32'd9);
        check("tmo_timeout", 32'(timeout), 32'd1);
        check("tmo_reg1", gotReg[1], 32'd3);

        // Zero-length program goes straight to RUN.
        clearEnv();
        buildModel(0);
        pulseStart(0);
        @(negedge clk);
        check("len0_coreHold", 32'(coreHold), 32'd0);
        check("len0_busy", 32'(busy), 32'd1);
        runTest("len0", 0, 0, 99, 1'b0, acc);
        check("len0_timeout", 32'(timeout), 32'd1);

        // Oversized request is clipped to PROG_DEPTH words.
        for (int i = 0; i < 7; i++) prog[i] = 32'h20210001;
        prog[7] = HALT;
        for (int i = 8; i < 12; i++) prog[i] = 32'h20420001;
        runTest("len12", 12, 12, 3, 1'b0, acc);
        check("len12_accepted", 32'(acc), 32'd8);
        check("len12_cycleCount", 32'(cycleCount), 32'd7);
        check("len12_timeout", 32'(timeout), 32'd0);
        check("len12_reg1", gotReg[1], 32'd7);
        check("len12_reg2", gotReg[2], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
